// File: rtl/mul_share_if.sv
// Request/result channel bundle for the shared multiplier controller.
// master: the requesters and result consumer; slave: the controller itself.
interface mul_share_if #(
    parameter int WIDTH = 4
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [2*WIDTH-1:0]   res_p;
    logic                 res_id;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_p, res_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_p, res_id
    );
endinterface

// File: rtl/mul_share_ctrl.sv
// Time-multiplexed shift-and-add multiplier shared by two requesters.
// Round-robin arbitration in IDLE, one partial product added per cycle in
// CALC, result held with the requester id in DONE until the consumer takes it.
module mul_share_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_share_if.slave    bus,
    output logic          busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               id_r;
    logic               last_grant_r;
    logic [PW-1:0]      acc_r;
    logic [CW-1:0]      cnt_r;
    logic               res_valid_r;
    logic               busy_r;
    logic               gnt0_s;
    logic               gnt1_s;
    logic               accept_s;
    logic               calc_last_s;

    // One shifted partial product: (a gated by the selected multiplier bit) << sh.
    function automatic logic [PW-1:0] partial_product(
        input logic [WIDTH-1:0] a,
        input logic             b_bit,
        input logic [CW-1:0]    sh
    );
        logic [PW-1:0] ext;
        ext = {{WIDTH{1'b0}}, (a & {WIDTH{b_bit}})};
        return ext << sh;
    endfunction

    assign accept_s    = gnt0_s | gnt1_s;
    assign calc_last_s = (cnt_r == CW'(WIDTH - 1));

    // Round-robin grant; readys are only offered in IDLE and never while in reset.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst_n && (state_r == ST_IDLE)) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (last_grant_r) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt1_s = 1'b1;
                end
            end else if (bus.req0_valid) begin
                gnt0_s = 1'b1;
            end else if (bus.req1_valid) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Next-state decode for the IDLE -> CALC -> DONE -> IDLE sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_CALC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (calc_last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture on accept and per-cycle accumulation of partial products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            id_r         <= 1'b0;
            last_grant_r <= 1'b1;
            acc_r        <= {PW{1'b0}};
            cnt_r        <= {CW{1'b0}};
        end else if (accept_s) begin
            a_r          <= gnt1_s ? bus.req1_a : bus.req0_a;
            b_r          <= gnt1_s ? bus.req1_b : bus.req0_b;
            id_r         <= gnt1_s;
            last_grant_r <= gnt1_s;
            acc_r        <= {PW{1'b0}};
            cnt_r        <= {CW{1'b0}};
        end else if (state_r == ST_CALC) begin
            acc_r <= acc_r + partial_product(a_r, b_r[cnt_r], cnt_r);
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Status outputs registered from the next state so they line up with state_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            res_valid_r <= (state_s == ST_DONE);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign bus.req0_ready = gnt0_s;
    assign bus.req1_ready = gnt1_s;
    assign bus.res_valid  = res_valid_r;
    assign bus.res_p      = acc_r;
    assign bus.res_id     = id_r;
    assign busy           = busy_r;

endmodule

// File: doc/mul_share_ctrl.md
# mul_share_ctrl

Sequential controller that shares one partial-product multiplier datapath between two requesters. It arbitrates round-robin and accepts one operand pair per transaction. The product is built by adding one shifted partial product (A & {W{B[i]}}) << i per cycle, and the result is returned with the requester ID on a valid/ready output channel. It sits between two client blocks and replaces two instances of the combinational 4-bit multiplier with one time-multiplexed unit.

## Interface
- WIDTH, default 4, operand width W; product width is 2W.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_ready  output  1  requester 0 pair accepted this cycle.
- req0_a, req0_b  input  W  requester 0 operands (unsigned).
- req1_valid  input  1  requester 1 has an operand pair.
- req1_ready  output  1  requester 1 pair accepted this cycle.
- req1_a, req1_b  input  W  requester 1 operands (unsigned).
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes the result.
- res_p  output  2W  product A*B.
- res_id  output  1  requester that issued this product.
- busy  output  1  high in CALC or DONE.

## Operation
- States:
  - IDLE: accepting.
  - CALC: accumulating.
  - DONE: holding the result.
- IDLE:
  - Only requester 0 valid: grant 0. Only requester 1 valid: grant 1.
  - Both valid: grant the requester not granted last time (last_grant register).
  - reqN_ready = IDLE & granted. It is combinational from valid and last_grant.
  - At most one ready is high per cycle. Neither ready is high outside IDLE.
- Accept edge (valid & ready):
  - Latch a_reg, b_reg, id_reg.
  - Clear acc and cnt. Update last_grant.
  - Go to CALC.
- CALC, each edge:
  - acc <= acc + ((a_reg & {W{b_reg[cnt]}}) << cnt).
  - cnt <= cnt + 1.
  - After the edge with cnt = W-1, go to DONE.
  - No early termination on zero operands. Latency is fixed.
- DONE:
  - res_valid = 1.
  - res_p = acc and res_id = id_reg, both held stable until handshake.
  - On res_valid & res_ready, go to IDLE. res_valid drops the next cycle.
- Width rules:
  - Operands are unsigned.
  - acc is 2W bits and cannot overflow; max (2^W-1)^2 < 2^2W.
  - cnt is clog2(W) bits.
- Requester operands are sampled only on the accept edge. Later changes on reqN_a/b are ignored.
- Reset (asynchronous, any state, including mid-CALC):
  - State = IDLE; acc, cnt, a_reg, b_reg, id_reg = 0.
  - last_grant = 1, so requester 0 wins the first contention.
  - All outputs 0: res_valid, res_p, res_id, busy, both readys.
  - An in-flight transaction is dropped silently and no result is produced.

## Timing
- Accept at edge E0. CALC edges are E1..EW. State is DONE after EW.
- res_valid is high in the cycle following EW, i.e. W cycles after accept (4 for W=4).
- Result consumed at edge Ec (res_ready high that cycle). State is IDLE after Ec.
- Earliest next accept is edge Ec+1. There is no same-cycle bypass from DONE to accept.
- Minimum period is W+2 cycles per product (6 for W=4), with res_ready held high.
- res_ready held low: DONE persists indefinitely, and both readys stay low.
- A requester may hold valid across busy periods. It must keep its operands stable until its ready handshake.
- Contention fairness: with both valid continuously, grants strictly alternate 0,1,0,1…

## Test plan
- Single request:
  - Stimulus: req0 A=3, B=2, res_ready=1.
  - Response: req0_ready pulses 1 cycle; res_valid rises exactly 4 cycles after accept with res_p=6, res_id=0; busy is high for 5 cycles.
- Contention after reset:
  - Stimulus: req0 (5,9) and req1 (15,15) both valid.
  - Response: first result res_p=45, id 0; second result res_p=225, id 1; accepts are 6 cycles apart.
- Backpressure:
  - Stimulus: req1 (7,6); res_ready low for 5 cycles after res_valid rises.
  - Response: res_p=42, id 1 held stable throughout; req0_ready and req1_ready stay 0 with both valid; completes on the res_ready edge.
- Round-robin:
  - Stimulus: both requesters valid for 4 transactions.
  - Response: res_id sequence 0,1,0,1.
- Reset mid-CALC:
  - Stimulus: accept req0 (15,15), assert rst_n=0 two cycles later.
  - Response: all outputs 0 immediately; no result after release; next contention grants req0.
- Exhaustive:
  - Stimulus: all 256 (A,B) pairs alternating on req0/req1 with random res_ready.
  - Response: every res_p = A*B, correct res_id, no lost or duplicated results.
